// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch/dispatch signal bundle for the instruction buffer
typedef struct packed {
  logic        valid;
  logic [31:0] inst;
} inst_packet_t;

interface inst_buffer_if #(
  parameter int N = 3,
  parameter int IB_SZ = 16
);
  logic                         flush;
  logic [$clog2(N+1)-1:0]       num_fetched;
  inst_packet_t [N-1:0]         fetched_insts;
  logic [$clog2(N+1)-1:0]       num_dispatch;
  inst_packet_t [N-1:0]         out_insts;
  logic [$clog2(IB_SZ+1)-1:0]   ib_open;
  logic [$clog2(IB_SZ+1)-1:0]   ib_count;
  modport master (
    output flush, num_fetched, fetched_insts, num_dispatch,
    input  out_insts, ib_open, ib_count
  );
  modport slave (
    input  flush, num_fetched, fetched_insts, num_dispatch,
    output out_insts, ib_open, ib_count
  );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and dispatch
module inst_buffer #(
  parameter int N = 3,
  parameter int IB_SZ = 16
) (
  input logic      clock,
  input logic      reset,
  inst_buffer_if.slave ib
);
  localparam int AW = $clog2(IB_SZ);
  localparam int CW = $clog2(IB_SZ + 1);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, open, nd, nf, pop, push;
  inst_packet_t [IB_SZ-1:0] entries_q, entries_d;
  always_comb begin
    open = CW'(IB_SZ) - count_q;
    nd = CW'(ib.num_dispatch);
    nf = CW'(ib.num_fetched);
    pop = (nd > count_q) ? count_q : nd;
    pop = (pop > CW'(N)) ? CW'(N) : pop;
    push = (nf > open) ? open : nf;
    push = (push > CW'(N)) ? CW'(N) : push;
    entries_d = entries_q;
    for (int j = 0; j < N; j++)
      if (CW'(j) < push) begin
        entries_d[tail_q + AW'(j)] = ib.fetched_insts[j];
        entries_d[tail_q + AW'(j)].valid = 1'b1;
      end
    if (ib.flush)
      for (int i = 0; i < IB_SZ; i++) entries_d[i].valid = 1'b0;
    head_d = ib.flush ? '0 : head_q + AW'(pop);
    tail_d = ib.flush ? '0 : tail_q + AW'(push);
    count_d = ib.flush ? '0 : count_q + push - pop;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      entries_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      entries_q <= entries_d;
    end
  always_comb begin
    ib.out_insts = '0;
    for (int i = 0; i < N; i++)
      ib.out_insts[i] = (CW'(i) < count_q) ? entries_q[head_q + AW'(i)] : '0;
  end
  assign ib.ib_open = CW'(IB_SZ) - count_q;
  assign ib.ib_count = count_q;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed checks of the instruction buffer
module tb_inst_buffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  inst_buffer_if #(.N(3), .IB_SZ(16)) ib ();
  inst_buffer #(.N(3), .IB_SZ(16)) dut (.clock(clock), .reset(reset), .ib(ib.slave));
  always #5 clock = ~clock;
  function automatic logic [63:0] pk(input logic [31:0] x);
    return {31'd0, 1'b1, x};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input int nf, input int nd, input logic [31:0] base);
    ib.num_fetched = 2'(nf);
    ib.num_dispatch = 2'(nd);
    for (int j = 0; j < 3; j++) ib.fetched_insts[j] = {1'b0, base + 32'(j)};
  endtask
  initial begin
    ib.flush = 1'b0;
    drive(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_open", 64'(ib.ib_open), 16);
    chk("rst_count", 64'(ib.ib_count), 0);
    chk("rst_out0", 64'(ib.out_insts[0]), 0);
    drive(3, 0, 32'hA);
    tick();
    drive(0, 0, 0);
    chk("abc_0", 64'(ib.out_insts[0]), pk(32'hA));
    chk("abc_1", 64'(ib.out_insts[1]), pk(32'hB));
    chk("abc_2", 64'(ib.out_insts[2]), pk(32'hC));
    chk("abc_count", 64'(ib.ib_count), 3);
    chk("abc_open", 64'(ib.ib_open), 13);
    drive(0, 2, 0);
    tick();
    drive(0, 0, 0);
    chk("pop2_0", 64'(ib.out_insts[0]), pk(32'hC));
    chk("pop2_1", 64'(ib.out_insts[1]), 0);
    chk("pop2_2", 64'(ib.out_insts[2]), 0);
    chk("pop2_open", 64'(ib.ib_open), 15);
    #3 reset = 1'b1;
    #1;
    chk("arst_out0", 64'(ib.out_insts[0]), 0);
    chk("arst_open", 64'(ib.ib_open), 16);
    chk("arst_count", 64'(ib.ib_count), 0);
    #2 reset = 1'b0;
    drive(2, 0, 32'h50);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(3, 3, 32'h60 + 32'(k * 3));
      tick();
    end
    drive(0, 3, 0);
    tick();
    chk("pre_wrap_count", 64'(ib.ib_count), 0);
    drive(3, 0, 32'hD0);
    tick();
    drive(0, 0, 0);
    chk("wrap_0", 64'(ib.out_insts[0]), pk(32'hD0));
    chk("wrap_1", 64'(ib.out_insts[1]), pk(32'hD1));
    chk("wrap_2", 64'(ib.out_insts[2]), pk(32'hD2));
    chk("wrap_count", 64'(ib.ib_count), 3);
    drive(0, 3, 0);
    tick();
    drive(0, 0, 0);
    chk("wrap_pop_count", 64'(ib.ib_count), 0);
    chk("wrap_pop_out0", 64'(ib.out_insts[0]), 0);
    for (int k = 0; k < 5; k++) begin
      drive(3, 0, 32'h100 + 32'(k * 3));
      tick();
    end
    drive(1, 0, 32'h10F);
    tick();
    drive(0, 0, 0);
    chk("full_count", 64'(ib.ib_count), 16);
    chk("full_open", 64'(ib.ib_open), 0);
    chk("full_out0", 64'(ib.out_insts[0]), pk(32'h100));
    chk("full_out2", 64'(ib.out_insts[2]), pk(32'h102));
    drive(3, 3, 32'h200);
    tick();
    drive(0, 0, 0);
    chk("full_pop_count", 64'(ib.ib_count), 13);
    chk("full_pop_open", 64'(ib.ib_open), 3);
    chk("full_pop_out0", 64'(ib.out_insts[0]), pk(32'h103));
    drive(1, 0, 32'h300);
    tick();
    chk("part_open_pre", 64'(ib.ib_open), 2);
    drive(3, 0, 32'h400);
    tick();
    drive(0, 0, 0);
    chk("part_open", 64'(ib.ib_open), 0);
    chk("part_count", 64'(ib.ib_count), 16);
    for (int k = 0; k < 4; k++) begin
      drive(0, 3, 0);
      tick();
    end
    drive(0, 2, 0);
    tick();
    drive(0, 0, 0);
    chk("part_count2", 64'(ib.ib_count), 2);
    chk("part_out0", 64'(ib.out_insts[0]), pk(32'h400));
    chk("part_out1", 64'(ib.out_insts[1]), pk(32'h401));
    chk("part_out2", 64'(ib.out_insts[2]), 0);
    ib.flush = 1'b1;
    drive(3, 2, 32'h500);
    #1;
    chk("flush_cycle_out0", 64'(ib.out_insts[0]), pk(32'h400));
    tick();
    ib.flush = 1'b0;
    drive(0, 0, 0);
    chk("flush_count", 64'(ib.ib_count), 0);
    chk("flush_open", 64'(ib.ib_open), 16);
    chk("flush_out0", 64'(ib.out_insts[0]), 0);
    chk("flush_out1", 64'(ib.out_insts[1]), 0);
    chk("flush_out2", 64'(ib.out_insts[2]), 0);
    drive(3, 0, 32'h600);
    tick();
    drive(0, 0, 0);
    chk("post_flush_0", 64'(ib.out_insts[0]), pk(32'h600));
    chk("post_flush_2", 64'(ib.out_insts[2]), pk(32'h602));
    chk("post_flush_count", 64'(ib.ib_count), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
